pipelined_vector_multiplication_unit: RTL
=========================================

Name: pipelined_vector_multiplication_unit

Overview:
Parametrised, pipelined successor to the combinational vector integer multiplier in the integer functional-unit cluster. It computes packed SEW-wide products (8/16/32/64-bit lanes, up to ELEN) under the same execution_vector controls: bit_mode, sign_mode, widening_mode and high_half_mode. It adds a configurable pipeline depth, valid/ready handshakes on both sides, per-element masking with byte enables for writeback, and a synchronous flush.

Parameters:
ELEN, 64, operand width in bits; power of two, 8..64; bit_mode values wider than ELEN are illegal.
LATENCY, 2, register stages from input acceptance to out_valid; 1..4.

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all in-flight operations
in_valid  input  1  operation presented
in_ready  output  1  unit can accept an operation this cycle
execution_vector  input  execution_vector_t  bit_mode, sign_mode, widening_mode, high_half_mode
vs2  input  ELEN  multiplicand (signed side in signed-unsigned mode)
vs1  input  ELEN  multiplier
mask  input  ELEN/8  element enables; bit i governs element i; only the low ELEN/SEW bits are used
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
vd  output  ELEN  low/narrow result
vd_high  output  ELEN  upper half of widened result
vd_byte_en  output  2*ELEN/8  byte enables; [ELEN/8-1:0] for vd, upper half for vd_high

Behaviour:
- Reset (asynchronous, any cycle): all stage valid bits clear. out_valid=0, vd=0, vd_high=0, vd_byte_en=0. in_ready=1 after release.
- Handshake: the pipeline advances when advance = !out_valid || out_ready. in_ready = advance. An operation is accepted on a cycle with in_valid && in_ready. A result is consumed on out_valid && out_ready.
- Latency: a result accepted at cycle t raises out_valid at t+LATENCY if it is never stalled. Throughput is 1 op/cycle. While advance=0, all stages, including the output, hold their data and valid bits. Outputs must not change while out_valid && !out_ready.
- Arithmetic, per element of SEW = 8<<bit_mode:
  - full 2*SEW-bit product.
  - Signed operands are sign-extended; unsigned operands are zero-extended.
  - Unsupported sign_mode or bit_mode: product forced to 0 and byte enables forced to 0.
- Result packing:
  - widening_mode enabled: element i's 2*SEW product occupies bits [2*SEW*i +: 2*SEW] of the concatenation {vd_high, vd}.
  - widening disabled, high_half_mode enabled: vd lane i = product[2*SEW-1:SEW]; vd_high=0.
  - otherwise: vd lane i = product[SEW-1:0]; vd_high=0.
  - widening takes precedence over high_half_mode.
- Masking:
  - mask[i]=0: element i's result bits are 0, and its byte enables are 0.
  - mask[i]=1: byte enables are set for every byte written by that element.
  - Non-widening ops always have vd_byte_en upper half = 0.
- flush:
  - On a flush cycle, all valid bits clear at the next edge, including the output stage, regardless of out_ready.
  - An op offered with in_valid in the same cycle is dropped.
  - in_ready stays 1 on the flush cycle.
  - Data registers may retain stale values, but vd, vd_high and vd_byte_en must read 0 when out_valid=0.
- Simultaneous accept and consume with the pipeline full: both occur; there is no bubble.
- Reset during a stall discards all state; no result is emitted after release.

Optional Feature:
Macro PIPELINED_VMUL_PERF_COUNTERS_EN.
- Defined: adds outputs perf_ops_completed (32 bits) and perf_stall_cycles (32 bits).
  - perf_ops_completed increments on each consumed result.
  - perf_stall_cycles increments each cycle with out_valid && !out_ready.
  - Both counters wrap modulo 2^32, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- 64-bit mode, signed-signed, vs2=-3, vs1=5, widening, mask=1, LATENCY=2: out_valid exactly 2 cycles after accept; {vd_high,vd}=-15 sign-extended to 128 bits; vd_byte_en=16'hFFFF.
- 8-bit mode, unsigned, high-half, vs2=vs1=64'hFFFF_FFFF_FFFF_FFFF, mask=8'hFF: vd=64'hFEFE_FEFE_FEFE_FEFE, vd_high=0, vd_byte_en=16'h00FF.
- 16-bit mode, signed-unsigned, vs2 lanes=16'h8000, vs1 lanes=16'h0002, low half, mask=8'b0101: vd=64'h0000_0000_0000_0000; lanes 0 and 2 have their enables set, lanes 1 and 3 enables clear; vd_byte_en=16'h0033.
- Back-to-back 6 ops with out_ready held 0 from cycle 3 to cycle 7: in_ready drops once the pipeline is full; results appear in order with no loss or duplication; outputs stable while stalled.
- flush asserted with 2 ops in flight and in_valid=1: no out_valid in the following LATENCY+2 cycles; in_ready stays 1.
- reset asserted mid-stall with out_valid=1: out_valid and vd drop to 0 asynchronously before the next clock edge; counters (if compiled in) read 0.

Source files
------------

// File: rtl/pipelined_vector_multiplication_unit.sv
// pipelined_vector_multiplication_unit
// Packed SEW-wide integer multiplier (SEW = 8 << bit_mode, up to ELEN) with a
// LATENCY-deep valid/ready pipeline, per-element masking and a synchronous flush.
//
// execution_vector field layout:
//   [2:0] bit_mode       : SEW = 8 << bit_mode; values with SEW > ELEN are unsupported
//   [4:3] sign_mode      : 0 = unsigned x unsigned, 1 = signed x signed,
//                          2 = signed vs2 x unsigned vs1, 3 = unsupported
//   [5]   widening_mode  : element i's 2*SEW product lands in {vd_high, vd}[2*SEW*i +: 2*SEW]
//   [6]   high_half_mode : non-widening ops return the upper SEW bits of each product
//
// Optional feature macro: PIPELINED_VMUL_PERF_COUNTERS_EN adds perf_ops_completed
// and perf_stall_cycles outputs.

module pipelined_vector_multiplication_unit #(
    parameter int ELEN    = 64,
    parameter int LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            execution_vector,
    input  logic [ELEN-1:0]       vs2,
    input  logic [ELEN-1:0]       vs1,
    input  logic [ELEN/8-1:0]     mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEN-1:0]       vd,
    output logic [ELEN-1:0]       vd_high,
    output logic [2*ELEN/8-1:0]   vd_byte_en
`ifdef PIPELINED_VMUL_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_ops_completed,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam int NB     = ELEN / 8;
    localparam int MAX_BM = $clog2(ELEN / 8);

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [2:0] bit_mode;
    logic [1:0] sign_mode;
    logic       widening_mode;
    logic       high_half_mode;
    logic       sign_a;
    logic       sign_b;
    logic       op_legal;

    assign bit_mode       = execution_vector[2:0];
    assign sign_mode      = execution_vector[4:3];
    assign widening_mode  = execution_vector[5];
    assign high_half_mode = execution_vector[6];

    // vs2 is the signed side for both signed-signed and signed-unsigned
    assign sign_a   = (sign_mode == 2'd1) || (sign_mode == 2'd2);
    assign sign_b   = (sign_mode == 2'd1);
    assign op_legal = (bit_mode <= 3'(MAX_BM)) && (sign_mode != 2'd3);

    // ------------------------------------------------------------------
    // Per-SEW lane multipliers, already masked and packed for each layout
    // ------------------------------------------------------------------
    logic [3:0][2*ELEN-1:0] mode_wide;
    logic [3:0][ELEN-1:0]   mode_lo;
    logic [3:0][ELEN-1:0]   mode_hi;
    logic [3:0][2*NB-1:0]   mode_wbe;
    logic [3:0][NB-1:0]     mode_nbe;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sew
            localparam int SEW = 8 << gi;
            if (SEW <= ELEN) begin : g_on
                localparam int LANES = ELEN / SEW;
                localparam int SB    = SEW / 8;
                for (gj = 0; gj < LANES; gj++) begin : g_lane
                    logic [SEW-1:0]   a_lane;
                    logic [SEW-1:0]   b_lane;
                    logic [2*SEW-1:0] a_ext;
                    logic [2*SEW-1:0] b_ext;
                    logic [2*SEW-1:0] prod;
                    logic [2*SEW-1:0] kept;

                    assign a_lane = vs2[SEW*gj +: SEW];
                    assign b_lane = vs1[SEW*gj +: SEW];
                    assign a_ext  = {{SEW{sign_a & a_lane[SEW-1]}}, a_lane};
                    assign b_ext  = {{SEW{sign_b & b_lane[SEW-1]}}, b_lane};
                    // The full product of any signed/unsigned SEW pair fits in 2*SEW
                    // bits, so the truncated 2*SEW x 2*SEW product is exact.
                    assign prod   = a_ext * b_ext;
                    assign kept   = mask[gj] ? prod : '0;

                    assign mode_wide[gi][2*SEW*gj +: 2*SEW] = kept;
                    assign mode_lo[gi][SEW*gj +: SEW]       = kept[SEW-1:0];
                    assign mode_hi[gi][SEW*gj +: SEW]       = kept[2*SEW-1:SEW];
                    assign mode_wbe[gi][2*SB*gj +: 2*SB]    = {(2*SB){mask[gj]}};
                    assign mode_nbe[gi][SB*gj +: SB]        = {SB{mask[gj]}};
                end
            end else begin : g_off
                assign mode_wide[gi] = '0;
                assign mode_lo[gi]   = '0;
                assign mode_hi[gi]   = '0;
                assign mode_wbe[gi]  = '0;
                assign mode_nbe[gi]  = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result selection by mode; unsupported modes yield zero data and enables
    // ------------------------------------------------------------------
    logic [ELEN-1:0] res_lo;
    logic [ELEN-1:0] res_hi;
    logic [2*NB-1:0] res_be;

    // Pick the packed layout for the requested SEW / widening / high-half mode
    always_comb begin
        res_lo = '0;
        res_hi = '0;
        res_be = '0;
        if (op_legal) begin
            if (widening_mode) begin
                {res_hi, res_lo} = mode_wide[bit_mode[1:0]];
                res_be           = mode_wbe[bit_mode[1:0]];
            end else begin
                res_lo = high_half_mode ? mode_hi[bit_mode[1:0]] : mode_lo[bit_mode[1:0]];
                res_be = {{NB{1'b0}}, mode_nbe[bit_mode[1:0]]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: the arithmetic feeds stage 0; stages 1..LATENCY-1 are plain
    // registers that retiming can pull back into the multiplier array.
    // ------------------------------------------------------------------
    logic                         advance;
    logic [LATENCY-1:0]           valid_reg;
    logic [LATENCY-1:0][ELEN-1:0] lo_reg;
    logic [LATENCY-1:0][ELEN-1:0] hi_reg;
    logic [LATENCY-1:0][2*NB-1:0] be_reg;

    assign out_valid = valid_reg[LATENCY-1];
    assign advance   = !out_valid || out_ready;
    // A flush cycle always reports ready: whatever is offered is dropped anyway.
    assign in_ready  = advance || flush;

    // Advance all stages together; flush kills every valid bit at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            be_reg    <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else if (advance) begin
            valid_reg[0] <= in_valid;
            lo_reg[0]    <= res_lo;
            hi_reg[0]    <= res_hi;
            be_reg[0]    <= res_be;
            for (int k = 1; k < LATENCY; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                lo_reg[k]    <= lo_reg[k-1];
                hi_reg[k]    <= hi_reg[k-1];
                be_reg[k]    <= be_reg[k-1];
            end
        end
    end

    // Stale data left behind by a flush must never be visible
    assign vd         = out_valid ? lo_reg[LATENCY-1] : '0;
    assign vd_high    = out_valid ? hi_reg[LATENCY-1] : '0;
    assign vd_byte_en = out_valid ? be_reg[LATENCY-1] : '0;

`ifdef PIPELINED_VMUL_PERF_COUNTERS_EN
    logic [31:0] ops_completed_reg;
    logic [31:0] stall_cycles_reg;

    // Count consumed results and back-pressure cycles; flush does not touch them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ops_completed_reg <= '0;
            stall_cycles_reg  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                ops_completed_reg <= ops_completed_reg + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_ops_completed = ops_completed_reg;
    assign perf_stall_cycles  = stall_cycles_reg;
`endif

endmodule
